// File: rtl/load_align.sv
// load_align: registered load-data alignment stage with a 2-entry output FIFO.
// Ports: Clk/Rst, In_valid/In_ready + Din/Addr_lo/Size/Sign_ext/Dest_in, Out_valid/Out_ready + Dout/Dest_out/Misalign.
module load_align #(
  parameter int DATA_W = 32,
  localparam int OFF_W = $clog2(DATA_W / 8)
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              In_valid,
  output logic              In_ready,
  input  logic [DATA_W-1:0] Din,
  input  logic [OFF_W-1:0]  Addr_lo,
  input  logic [1:0]        Size,
  input  logic              Sign_ext,
  input  logic [4:0]        Dest_in,
  output logic              Out_valid,
  input  logic              Out_ready,
  output logic [DATA_W-1:0] Dout,
  output logic [4:0]        Dest_out,
  output logic              Misalign
);

  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] mask;
  logic [DATA_W-1:0] top;
  logic [DATA_W-1:0] fill;
  logic [DATA_W-1:0] res;
  logic [3:0]        off;
  logic [6:0]        fw;
  logic              msb;
  logic              bad;

  // Field is brought to bit 0, then masked to its width; the bits
  // above the mask are filled with the field MSB when sign-extending.
  // A full-width field gets an all-ones mask, so Din passes unchanged.
  always_comb begin
    off     = 4'(Addr_lo);
    shifted = Din >> {off, 3'b000};
    fw      = 7'd8 << Size;
    if (fw > 7'(DATA_W)) fw = 7'(DATA_W);
    mask    = {DATA_W{1'b1}} >> (7'(DATA_W) - fw);
    top     = mask & ~(mask >> 1);
    msb     = |(shifted & top);
    fill    = (Sign_ext && msb) ? ~mask : '0;
    res     = (shifted & mask) | fill;
    bad     = 1'b0;
    unique case (Size)
      2'd0: bad = 1'b0;
      2'd1: bad = off[0];
      2'd2: bad = off[1:0] != 2'd0;
      2'd3: bad = (DATA_W == 32) || (off[2:0] != 3'd0);
    endcase
    if (bad) res = '0;
  end

  logic [DATA_W-1:0] mem_d [2];
  logic [4:0]        mem_t [2];
  logic              mem_m [2];
  logic [1:0]        count;
  logic              wr_ptr;
  logic              rd_ptr;
  logic              push;
  logic              pop;

  assign In_ready  = Rst && (count < 2'd2);
  assign Out_valid = count != 2'd0;
  assign push      = In_valid && In_ready;
  assign pop       = Out_valid && Out_ready;

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (push) begin
        mem_d[wr_ptr] <= res;
        mem_t[wr_ptr] <= Dest_in;
        mem_m[wr_ptr] <= bad;
        wr_ptr        <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Outputs read zero whenever the buffer is empty, including reset.
  assign Dout     = Out_valid ? mem_d[rd_ptr] : '0;
  assign Dest_out = Out_valid ? mem_t[rd_ptr] : 5'd0;
  assign Misalign = Out_valid ? mem_m[rd_ptr] : 1'b0;

endmodule
